// File: rtl/riscv_wb_checker.sv
// Writeback checker: shadows architectural writebacks during a run, then scans an expected-value table.
// Optional RISCV_CHECKER_WBCNT_EN adds wb_count_o, a count of accepted non-x0 writebacks.
module riscv_wb_checker #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_CHECKS = 8,
  parameter int RUN_CYCLES = 64,
  parameter int RW         = $clog2(NUM_REGS),
  parameter int CW         = $clog2(NUM_CHECKS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic            wb_en_i,
  input  logic [RW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            exp_wr_i,
  input  logic [CW-1:0]   exp_idx_i,
  input  logic [RW-1:0]   exp_rd_i,
  input  logic [XLEN-1:0] exp_data_i,
  input  logic            exp_valid_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic            timeout_o,
  output logic [CW:0]     fail_count_o,
  output logic [CW-1:0]   first_fail_o
`ifdef RISCV_CHECKER_WBCNT_EN
  ,
  output logic [31:0]     wb_count_o
`endif
);

  localparam int TW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [TW-1:0]   run_cnt;
  logic [CW-1:0]   chk_idx;
  logic [CW:0]     fail_cnt;
  logic [CW-1:0]   first_fail;
  logic            timeout;
  logic            any_valid;

  logic [XLEN-1:0] shadow   [NUM_REGS];
  logic            tbl_v    [NUM_CHECKS];
  logic [RW-1:0]   tbl_rd   [NUM_CHECKS];
  logic [XLEN-1:0] tbl_data [NUM_CHECKS];

  logic            idle_like;
  logic            go;
  logic            expire;
  logic            wb_acc;
  logic [RW-1:0]   cur_rd;
  logic [XLEN-1:0] cur_val;
  logic            mismatch;
  logic            last;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign go        = idle_like && start_i;
  assign expire    = run_cnt == TW'(RUN_CYCLES - 1);
  assign wb_acc    = (state == S_RUN) && wb_en_i
                     && (wb_rd_i != '0);
  assign cur_rd    = tbl_rd[chk_idx];
  assign cur_val   = (cur_rd == '0) ? '0 : shadow[cur_rd];
  assign mismatch  = tbl_v[chk_idx]
                     && (cur_val != tbl_data[chk_idx]);
  assign last      = chk_idx == CW'(NUM_CHECKS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      run_cnt    <= '0;
      chk_idx    <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
      timeout    <= 1'b0;
      any_valid  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state      <= S_RUN;
            run_cnt    <= '0;
            chk_idx    <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            timeout    <= 1'b0;
            any_valid  <= 1'b0;
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (halt_i || expire) begin
            state   <= S_CHECK;
            chk_idx <= '0;
            // halt wins when it coincides with expiry
            timeout <= expire && !halt_i;
          end
        end
        default: begin
          chk_idx <= chk_idx + 1'b1;
          if (tbl_v[chk_idx])
            any_valid <= 1'b1;
          if (mismatch) begin
            if (fail_cnt == '0)
              first_fail <= chk_idx;
            if (fail_cnt != (CW+1)'(NUM_CHECKS))
              fail_cnt <= fail_cnt + 1'b1;
          end
          if (last)
            state <= S_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        shadow[i] <= '0;
    end else if (go) begin
      for (int i = 0; i < NUM_REGS; i++)
        shadow[i] <= '0;
    end else if (wb_acc) begin
      shadow[wb_rd_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_v[i]    <= 1'b0;
        tbl_rd[i]   <= '0;
        tbl_data[i] <= '0;
      end
    end else if (idle_like && exp_wr_i) begin
      tbl_v[exp_idx_i]    <= exp_valid_i;
      tbl_rd[exp_idx_i]   <= exp_rd_i;
      tbl_data[exp_idx_i] <= exp_data_i;
    end
  end

`ifdef RISCV_CHECKER_WBCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wb_count_o <= '0;
    else if (go)
      wb_count_o <= '0;
    else if (wb_acc)
      wb_count_o <= wb_count_o + 32'd1;
  end
`endif

  assign busy_o       = (state == S_RUN) || (state == S_CHECK);
  assign done_o       = state == S_DONE;
  assign pass_o       = done_o && (fail_cnt == '0)
                        && !timeout && any_valid;
  assign timeout_o    = timeout;
  assign fail_count_o = fail_cnt;
  assign first_fail_o = first_fail;

endmodule

// File: tb/tb_riscv_wb_checker.sv
// Randomized bench for riscv_wb_checker against a table/array reference model.
// Exercises directed pass/fail/x0/timeout/reset/ignored-input runs, then random runs.
module tb_riscv_wb_checker;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NC   = 8;
  localparam int RC   = 16;
  localparam int RW   = $clog2(NR);
  localparam int CW   = $clog2(NC);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic            halt_i = 1'b0;
  logic            wb_en_i = 1'b0;
  logic [RW-1:0]   wb_rd_i = '0;
  logic [XLEN-1:0] wb_data_i = '0;
  logic            exp_wr_i = 1'b0;
  logic [CW-1:0]   exp_idx_i = '0;
  logic [RW-1:0]   exp_rd_i = '0;
  logic [XLEN-1:0] exp_data_i = '0;
  logic            exp_valid_i = 1'b0;
  logic            busy_o, done_o, pass_o, timeout_o;
  logic [CW:0]     fail_count_o;
  logic [CW-1:0]   first_fail_o;
`ifdef RISCV_CHECKER_WBCNT_EN
  logic [31:0]     wb_count_o;
`endif

  riscv_wb_checker #(
    .XLEN(XLEN), .NUM_REGS(NR),
    .NUM_CHECKS(NC), .RUN_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .halt_i(halt_i),
    .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i),
    .exp_wr_i(exp_wr_i), .exp_idx_i(exp_idx_i),
    .exp_rd_i(exp_rd_i), .exp_data_i(exp_data_i),
    .exp_valid_i(exp_valid_i),
    .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .timeout_o(timeout_o),
    .fail_count_o(fail_count_o),
    .first_fail_o(first_fail_o)
`ifdef RISCV_CHECKER_WBCNT_EN
    ,
    .wb_count_o(wb_count_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model
  logic [XLEN-1:0] m_sh [NR];
  logic            m_v  [NC];
  int              m_rd [NC];
  logic [XLEN-1:0] m_dat[NC];
  int              m_wbc;

  // directed writeback script, one slot per RUN cycle
  logic            d_en [RC];
  int              d_rd [RC];
  logic [XLEN-1:0] d_dat[RC];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_dir();
    for (int i = 0; i < RC; i++) begin
      d_en[i] = 1'b0; d_rd[i] = 0; d_dat[i] = '0;
    end
  endtask

  task automatic tbl_wr(input int idx, input bit v,
                        input int rd, input int dat);
    @(negedge clk);
    exp_wr_i = 1'b1; exp_idx_i = CW'(idx);
    exp_valid_i = v; exp_rd_i = RW'(rd);
    exp_data_i = XLEN'(dat);
    m_v[idx] = v; m_rd[idx] = rd;
    m_dat[idx] = XLEN'(dat);
    @(negedge clk);
    exp_wr_i = 1'b0;
  endtask

  task automatic clr_tbl();
    for (int i = 0; i < NC; i++) tbl_wr(i, 0, 0, 0);
  endtask

  task automatic do_run(input string tag, input int halt_at,
                        input bit rnd, input int inj_k);
    bit halted;
    int n, fails, first, nval;
    logic [XLEN-1:0] v;
    @(negedge clk);
    start_i = 1'b1;
    for (int i = 0; i < NR; i++) m_sh[i] = '0;
    m_wbc = 0;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, ".run_busy"}, busy_o, 1);
    chk({tag, ".run_done"}, {done_o, pass_o}, 0);
    halted = 0;
    for (int k = 0; k < RC; k++) begin
      if (rnd) begin
        wb_en_i = ($urandom_range(0, 9) < 6);
        wb_rd_i = RW'($urandom_range(0, 7));
        wb_data_i = XLEN'($urandom_range(0, 3));
      end else begin
        wb_en_i = d_en[k]; wb_rd_i = RW'(d_rd[k]);
        wb_data_i = d_dat[k];
      end
      halt_i = (k == halt_at);
      if (k == inj_k) begin
        start_i = 1'b1; exp_wr_i = 1'b1;
        exp_idx_i = CW'($urandom_range(0, NC-1));
        exp_valid_i = 1'b1;
        exp_rd_i = RW'($urandom_range(1, 7));
        exp_data_i = XLEN'($urandom);
      end
      if (wb_en_i && wb_rd_i != 0) begin
        m_sh[wb_rd_i] = wb_data_i;
        m_wbc++;
      end
      @(negedge clk);
      wb_en_i = 1'b0; halt_i = 1'b0;
      start_i = 1'b0; exp_wr_i = 1'b0;
      if (k == halt_at) begin
        halted = 1;
        break;
      end
    end
    n = 0;
    while (busy_o && !done_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    fails = 0; first = 0; nval = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_v[i]) begin
        nval++;
        v = (m_rd[i] == 0) ? '0 : m_sh[m_rd[i]];
        if (v != m_dat[i]) begin
          if (fails == 0) first = i;
          fails++;
        end
      end
    end
    chk({tag, ".chk_cycles"}, n, NC);
    chk({tag, ".done"}, {done_o, busy_o}, 2'b10);
    chk({tag, ".timeout"}, timeout_o, !halted);
    chk({tag, ".fcnt"}, fail_count_o, fails);
    chk({tag, ".ffirst"}, first_fail_o, first);
    chk({tag, ".pass"}, pass_o,
        (fails == 0 && halted && nval > 0));
`ifdef RISCV_CHECKER_WBCNT_EN
    chk({tag, ".wbcnt"}, wb_count_o, m_wbc);
`endif
    @(negedge clk);
    chk({tag, ".done_hold"}, done_o, 1);
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      m_v[i] = 0; m_rd[i] = 0; m_dat[i] = '0;
    end
    clr_dir();
    #12;
    chk("rst.outs", {busy_o, done_o, pass_o, timeout_o,
        fail_count_o, first_fail_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic pass
    tbl_wr(0, 1, 1, 10); tbl_wr(1, 1, 2, 20);
    tbl_wr(2, 1, 3, 30); tbl_wr(3, 1, 4, 30);
    clr_dir();
    for (int i = 0; i < 4; i++) begin
      d_en[i] = 1; d_rd[i] = i + 1;
      d_dat[i] = XLEN'((i == 3) ? 30 : 10 * (i + 1));
    end
    do_run("pass", 3, 0, -1);
    chk("pass.p", pass_o, 1);

    // single mismatch at entry 2
    tbl_wr(2, 1, 3, 31);
    do_run("fail", 3, 0, -1);
    chk("fail.cnt", fail_count_o, 1);

    // ignored start/table write during RUN
    tbl_wr(2, 1, 3, 30);
    do_run("inj", 5, 0, 1);
    chk("inj.p", pass_o, 1);

    // x0 writeback dropped
    clr_tbl();
    tbl_wr(0, 1, 0, 0);
    clr_dir();
    d_en[0] = 1; d_rd[0] = 0; d_dat[0] = 5;
    do_run("x0", 1, 0, -1);

    // timeout with no halt
    do_run("tmo", -1, 0, -1);

    // reset mid-run
    tbl_wr(0, 1, 1, 10);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wb_en_i = 1'b1; wb_rd_i = 1; wb_data_i = 10;
    @(negedge clk);
    wb_en_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.outs", {busy_o, done_o, pass_o, timeout_o,
        fail_count_o, first_fail_o}, 0);
    for (int i = 0; i < NC; i++) m_v[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mrst.idle", {busy_o, done_o}, 0);
    tbl_wr(0, 1, 1, 0);
    clr_dir();
    do_run("mrst", 0, 0, -1);
    chk("mrst.p", pass_o, 1);

    // random runs
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3))
        tbl_wr($urandom_range(0, NC-1),
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 7),
               $urandom_range(0, 3));
      do_run($sformatf("rnd%0d", r), $urandom_range(0, 20),
             1, ($urandom_range(0, 3) == 0) ?
                $urandom_range(0, 5) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_wb_checker.md
RISCV_WB_CHECKER -- requirements
Module: riscv_wb_checker

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_REGS, default 32, architectural register count; RW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_CHECKS, default 8, expected-value table depth; CW = $clog2(NUM_CHECKS).
REQ-004 SHALL have parameter RUN_CYCLES, default 64, maximum RUN window in clocks.
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin a run.
- halt_i  in  1  core reports program end.
- wb_en_i  in  1  writeback valid.
- wb_rd_i  in  RW  writeback destination.
- wb_data_i  in  XLEN  writeback data.
- exp_wr_i  in  1  table write strobe.
- exp_idx_i  in  CW  table entry index.
- exp_rd_i  in  RW  expected register.
- exp_data_i  in  XLEN  expected value.
- exp_valid_i  in  1  entry valid bit.
- busy_o  out  1  RUN or CHECK.
- done_o  out  1  results valid.
- pass_o  out  1  run passed.
- timeout_o  out  1  window expired without halt.
- fail_count_o  out  CW+1  mismatching entries.
- first_fail_o  out  CW  lowest failing entry index.

Function
REQ-006 SHALL implement FSM IDLE -> RUN -> CHECK -> DONE; DONE -> RUN on start_i.
REQ-007 IDLE/DONE: start_i SHALL clear the shadow file, counters, and flags, then enter RUN next cycle; in RUN/CHECK, start_i SHALL be ignored.
REQ-008 exp_wr_i SHALL write {valid, rd, data} to entry exp_idx_i only in IDLE/DONE; it SHALL be ignored otherwise; table contents SHALL survive start_i.
REQ-009 RUN: wb_en_i with wb_rd_i != 0 SHALL update shadow[wb_rd_i] at the clock edge; writes to x0 SHALL be dropped; shadow[0] reads 0.
REQ-010 RUN: a cycle counter SHALL increment from 0; RUN SHALL exit to CHECK on halt_i or when the counter reaches RUN_CYCLES-1, whichever is first.
REQ-011 On exit by expiry without halt_i, timeout_o SHALL set; if halt_i and expiry coincide, halt_i wins and timeout_o stays 0.
REQ-012 A writeback in the same cycle as halt_i or expiry SHALL be captured; writebacks in CHECK/DONE/IDLE SHALL be ignored.
REQ-013 CHECK SHALL scan entries 0..NUM_CHECKS-1, one per cycle, taking exactly NUM_CHECKS cycles; invalid entries SHALL be skipped without counting.
REQ-014 A valid entry with shadow[rd] != data SHALL increment fail_count_o; the first such entry SHALL load first_fail_o.
REQ-015 done_o SHALL assert the cycle after the last CHECK entry and hold until start_i or reset.
REQ-016 pass_o SHALL be 1 in DONE iff fail_count_o == 0, timeout_o == 0, and at least one valid entry was checked; it SHALL be 0 outside DONE.
REQ-017 fail_count_o SHALL saturate at NUM_CHECKS; first_fail_o SHALL be 0 when fail_count_o == 0.

Reset
REQ-018 rst_n low SHALL, asynchronously, force IDLE, clear all shadow registers, table valid bits, and counters, and drive every output to 0.
REQ-019 Reset during RUN or CHECK SHALL abort the run with no done_o pulse; operation SHALL resume in IDLE on the first edge after release.

Configuration
REQ-020 With RISCV_CHECKER_WBCNT_EN defined, the block SHALL add output wb_count_o (32 bits), counting accepted non-x0 writebacks in RUN, cleared by start_i and reset, and held in DONE.
REQ-021 Without RISCV_CHECKER_WBCNT_EN, the port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-022 Load {x1=10, x2=20, x3=30, x4=30}, start, drive those writebacks, halt -> done_o after NUM_CHECKS cycles, pass_o=1, fail_count_o=0.
REQ-023 Same stimulus with entry 2 expecting x3=31 -> pass_o=0, fail_count_o=1, first_fail_o=2.
REQ-024 Writeback x0=5 with entry expecting x0=0 -> pass_o=1; with WBCNT enabled, wb_count_o excludes it.
REQ-025 RUN_CYCLES=16, no halt_i -> CHECK entered after 16 RUN cycles, timeout_o=1, pass_o=0.
REQ-026 Assert rst_n low mid-RUN after x1=10 -> outputs 0, no done_o; restart with the same table -> x1 shadow starts at 0.
REQ-027 start_i and exp_wr_i pulsed during RUN -> both ignored, table unchanged, run completes normally.
